// File: rtl/lpif_tx_half_pack_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lpif_pack_pkg
// Shared definitions for the LPIF upstream half-pack controller:
//   - beat / word widths
//   - bit offsets of the LPIF beat fields inside the lower and upper halves
//   - the pack FSM state encoding
//   - small helpers for building the zero upper half of a word
// ---------------------------------------------------------------------------
package lpif_pack_pkg;

  localparam int BEAT_W = 537;
  localparam int WORD_W = 2 * BEAT_W;
  localparam int CNT_W  = 16;

  // Field offsets inside one beat: {valid, crc_valid, crc, dvalid, data, protid, state}
  localparam int STATE_LSB  = 0;
  localparam int PROTID_LSB = 4;
  localparam int DATA_LSB   = 6;
  localparam int DVALID     = 518;
  localparam int CRC_LSB    = 519;
  localparam int CRCV       = 535;
  localparam int VALID      = 536;

  // Same fields when the beat sits in the upper half of a FIFO word
  localparam int UP_STATE_LSB  = STATE_LSB  + BEAT_W;
  localparam int UP_PROTID_LSB = PROTID_LSB + BEAT_W;
  localparam int UP_DATA_LSB   = DATA_LSB   + BEAT_W;
  localparam int UP_DVALID     = DVALID     + BEAT_W;
  localparam int UP_CRC_LSB    = CRC_LSB    + BEAT_W;
  localparam int UP_CRCV       = CRCV       + BEAT_W;
  localparam int UP_VALID      = VALID      + BEAT_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pack_state_e;

  // All-zero beat used for gen1 upper halves and flush padding
  function automatic logic [BEAT_W-1:0] zero_beat();
    return {BEAT_W{1'b0}};
  endfunction

  // Wrapping increment of a statistics counter
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/lpif_tx_half_pack_ctrl.sv
// ---------------------------------------------------------------------------
// lpif_tx_half_pack_ctrl
// Packs LPIF upstream beats into TX FIFO words. In gen2 mode two consecutive
// beats form one word (first beat in the lower half); in gen1 mode each beat
// forms one word with a zero upper half. A flush request closes a half-filled
// word with a zero pad.
//
// Ports:
//   clk_wr                 in   write-domain clock
//   rst_wr_n               in   synchronous active-low reset
//   m_gen2_mode            in   1 = two beats per word, 0 = one beat per word
//   ustrm_beat             in   upstream LPIF beat (BEAT_W)
//   ustrm_beat_vld         in   beat valid
//   ustrm_beat_rdy         out  beat accepted when vld & rdy
//   flush_req              in   close a half word with a zero pad
//   txfifo_upstream_data   out  registered FIFO word (WORD_W)
//   txfifo_push            out  FIFO write strobe
//   txfifo_full            in   FIFO full
//   busy                   out  a half or full word is held
//   word_cnt               out  words pushed (wrapping)
//   pad_cnt                out  words closed by a pad (wrapping)
// ---------------------------------------------------------------------------
module lpif_tx_half_pack_ctrl
  import lpif_pack_pkg::*;
(
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              m_gen2_mode,
  input  logic [BEAT_W-1:0] ustrm_beat,
  input  logic              ustrm_beat_vld,
  output logic              ustrm_beat_rdy,
  input  logic              flush_req,
  output logic [WORD_W-1:0] txfifo_upstream_data,
  output logic              txfifo_push,
  input  logic              txfifo_full,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  pad_cnt
);

  pack_state_e       state_q,    state_d;
  logic [WORD_W-1:0] data_q,     data_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  pad_cnt_q,  pad_cnt_d;

  logic push_s;
  logic rdy_s;
  logic accept_s;

  // Handshake: push and ready are decoded from the state register and the
  // live FIFO-full flag, and forced low while reset is asserted.
  always_comb begin
    push_s = 1'b0;
    rdy_s  = 1'b0;
    if (!rst_wr_n) begin
      push_s = 1'b0;
      rdy_s  = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          push_s = 1'b0;
          rdy_s  = 1'b1;
        end
        HALF: begin
          push_s = 1'b0;
          rdy_s  = 1'b1;
        end
        FULL: begin
          push_s = ~txfifo_full;
          rdy_s  = ~txfifo_full;
        end
        default: begin
          push_s = 1'b0;
          rdy_s  = 1'b0;
        end
      endcase
    end
    accept_s = ustrm_beat_vld & rdy_s;
  end

  // Next-state, data and counter logic for the pack FSM
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pad_cnt_d  = pad_cnt_q;
    word_cnt_d = word_cnt_q;

    if (push_s) begin
      word_cnt_d = cnt_inc(word_cnt_q);
    end else begin
      word_cnt_d = word_cnt_q;
    end

    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          data_d[BEAT_W-1:0] = ustrm_beat;
          if (m_gen2_mode) begin
            state_d = HALF;
          end else begin
            data_d[WORD_W-1:BEAT_W] = zero_beat();
            state_d                 = FULL;
          end
        end else begin
          state_d = EMPTY;
        end
      end

      HALF: begin
        // A beat arriving together with a flush wins; the flush is dropped.
        if (accept_s) begin
          data_d[WORD_W-1:BEAT_W] = ustrm_beat;
          state_d                 = FULL;
        end else if (flush_req) begin
          data_d[WORD_W-1:BEAT_W] = zero_beat();
          pad_cnt_d               = cnt_inc(pad_cnt_q);
          state_d                 = FULL;
        end else begin
          state_d = HALF;
        end
      end

      FULL: begin
        // Data is only rewritten by a new accept, so the word stays stable
        // while a push is held off by txfifo_full. Accepting during the push
        // cycle reloads as if from EMPTY, giving zero-bubble streaming.
        if (push_s) begin
          if (accept_s) begin
            data_d[BEAT_W-1:0] = ustrm_beat;
            if (m_gen2_mode) begin
              state_d = HALF;
            end else begin
              data_d[WORD_W-1:BEAT_W] = zero_beat();
              state_d                 = FULL;
            end
          end else begin
            state_d = EMPTY;
          end
        end else begin
          state_d = FULL;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, word and counter registers with synchronous active-low reset
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_q    <= EMPTY;
      data_q     <= {WORD_W{1'b0}};
      word_cnt_q <= {CNT_W{1'b0}};
      pad_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      word_cnt_q <= word_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
    end
  end

  assign txfifo_push          = push_s;
  assign ustrm_beat_rdy       = rdy_s;
  assign txfifo_upstream_data = data_q;
  assign busy                 = (state_q != EMPTY);
  assign word_cnt             = word_cnt_q;
  assign pad_cnt              = pad_cnt_q;

endmodule

// File: tb/tb_lpif_tx_half_pack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lpif_tx_half_pack_ctrl
// Scoreboard bench: every time stimulus completes a word, the expected
// {upper, lower, push cycle} is queued; a negedge monitor pops and compares
// on each txfifo_push. Inline checks cover handshake, counters and reset.
// ---------------------------------------------------------------------------
module tb_lpif_tx_half_pack_ctrl;
  import lpif_pack_pkg::*;

  localparam int BW = 537;

  typedef struct {
    logic [BW-1:0] lo;
    logic [BW-1:0] hi;
    int            cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_wr_n;
  logic              m_gen2_mode;
  logic [BEAT_W-1:0] ustrm_beat;
  logic              ustrm_beat_vld;
  logic              ustrm_beat_rdy;
  logic              flush_req;
  logic [WORD_W-1:0] txfifo_upstream_data;
  logic              txfifo_push;
  logic              txfifo_full;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  pad_cnt;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  lpif_tx_half_pack_ctrl dut (
    .clk_wr               (clk),
    .rst_wr_n             (rst_wr_n),
    .m_gen2_mode          (m_gen2_mode),
    .ustrm_beat           (ustrm_beat),
    .ustrm_beat_vld       (ustrm_beat_vld),
    .ustrm_beat_rdy       (ustrm_beat_rdy),
    .flush_req            (flush_req),
    .txfifo_upstream_data (txfifo_upstream_data),
    .txfifo_push          (txfifo_push),
    .txfifo_full          (txfifo_full),
    .busy                 (busy),
    .word_cnt             (word_cnt),
    .pad_cnt              (pad_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index, advanced on every active edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input logic [7:0] tag);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < 17; i++) begin
      b = {b[BW-33:0], $urandom()};
    end
    b[7:0] = tag;
    return b;
  endfunction

  function automatic exp_t mk_exp(input logic [BW-1:0] lo, input logic [BW-1:0] hi, input int c);
    exp_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.cyc = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every push against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (txfifo_push) begin
      if (sb.size() == 0) begin
        check_eq("push_unexpected", BW'(txfifo_push), BW'(0));
      end else begin
        e = sb.pop_front();
        check_eq("push_lo",  txfifo_upstream_data[BEAT_W-1:0], e.lo);
        check_eq("push_hi",  txfifo_upstream_data[WORD_W-1:BEAT_W], e.hi);
        check_eq("push_cyc", BW'(cyc), BW'(e.cyc));
      end
    end
  end

  initial begin
    logic [BW-1:0] a, b, c, d;
    logic [BW-1:0] zero;
    zero           = '0;
    rst_wr_n       = 1'b0;
    m_gen2_mode    = 1'b1;
    ustrm_beat     = '0;
    ustrm_beat_vld = 1'b0;
    flush_req      = 1'b0;
    txfifo_full    = 1'b0;

    // ---- reset state, with a beat offered during reset ----
    repeat (3) tick();
    ustrm_beat     = mk_beat(8'h11);
    ustrm_beat_vld = 1'b1;
    #1;
    check_eq("rst_rdy",   BW'(ustrm_beat_rdy), BW'(0));
    check_eq("rst_push",  BW'(txfifo_push), BW'(0));
    check_eq("rst_busy",  BW'(busy), BW'(0));
    check_eq("rst_data",  txfifo_upstream_data[BEAT_W-1:0], zero);
    check_eq("rst_wcnt",  BW'(word_cnt), BW'(0));
    check_eq("rst_pcnt",  BW'(pad_cnt), BW'(0));
    tick();
    ustrm_beat_vld = 1'b0;
    rst_wr_n       = 1'b1;
    tick();

    // ---- gen2 back-to-back ----
    a = mk_beat(8'hA1);
    b = mk_beat(8'hB2);
    sb.push_back(mk_exp(a, b, cyc + 2));
    m_gen2_mode = 1'b1; ustrm_beat_vld = 1'b1; ustrm_beat = a;
    #1; check_eq("g2_rdy_empty", BW'(ustrm_beat_rdy), BW'(1));
    tick();
    ustrm_beat = b;
    #1; check_eq("g2_busy_half", BW'(busy), BW'(1));
    tick();
    ustrm_beat_vld = 1'b0;
    repeat (2) tick();
    check_eq("g2_wcnt", BW'(word_cnt), BW'(1));
    check_eq("g2_idle", BW'(busy), BW'(0));

    // ---- gen1 streaming, 8 beats ----
    m_gen2_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = mk_beat(8'h30 + 8'(i));
      sb.push_back(mk_exp(a, zero, cyc + 1));
      ustrm_beat_vld = 1'b1; ustrm_beat = a;
      tick();
    end
    ustrm_beat_vld = 1'b0;
    repeat (2) tick();
    check_eq("g1_wcnt", BW'(word_cnt), BW'(9));

    // ---- backpressure ----
    m_gen2_mode = 1'b1;
    a = mk_beat(8'h51); b = mk_beat(8'h52); c = mk_beat(8'h53); d = mk_beat(8'h54);
    sb.push_back(mk_exp(a, b, cyc + 7));
    sb.push_back(mk_exp(c, d, cyc + 9));
    txfifo_full = 1'b1; ustrm_beat_vld = 1'b1; ustrm_beat = a;
    tick();
    ustrm_beat = b;
    tick();
    ustrm_beat = c;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_rdy",  BW'(ustrm_beat_rdy), BW'(0));
      check_eq("bp_push", BW'(txfifo_push), BW'(0));
      check_eq("bp_lo",   txfifo_upstream_data[BEAT_W-1:0], a);
      check_eq("bp_hi",   txfifo_upstream_data[WORD_W-1:BEAT_W], b);
      tick();
    end
    txfifo_full = 1'b0;
    #1; check_eq("bp_rdy_release", BW'(ustrm_beat_rdy), BW'(1));
    tick();
    ustrm_beat = d;
    tick();
    ustrm_beat_vld = 1'b0;
    repeat (2) tick();
    check_eq("bp_wcnt", BW'(word_cnt), BW'(11));

    // ---- flush padding, then flush colliding with a beat ----
    a = mk_beat(8'h61);
    sb.push_back(mk_exp(a, zero, cyc + 2));
    ustrm_beat_vld = 1'b1; ustrm_beat = a;
    tick();
    ustrm_beat_vld = 1'b0; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (2) tick();
    check_eq("fl_pcnt", BW'(pad_cnt), BW'(1));
    c = mk_beat(8'h63); d = mk_beat(8'h64);
    sb.push_back(mk_exp(c, d, cyc + 2));
    ustrm_beat_vld = 1'b1; ustrm_beat = c;
    tick();
    ustrm_beat = d; flush_req = 1'b1;
    tick();
    ustrm_beat_vld = 1'b0; flush_req = 1'b0;
    repeat (2) tick();
    check_eq("fl_collide_pcnt", BW'(pad_cnt), BW'(1));
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (2) tick();
    check_eq("fl_empty_pcnt", BW'(pad_cnt), BW'(1));
    check_eq("fl_empty_busy", BW'(busy), BW'(0));
    check_eq("fl_wcnt", BW'(word_cnt), BW'(13));

    // ---- mode change while HALF ----
    a = mk_beat(8'h71); b = mk_beat(8'h72); c = mk_beat(8'h73);
    sb.push_back(mk_exp(a, b, cyc + 2));
    sb.push_back(mk_exp(c, zero, cyc + 3));
    m_gen2_mode = 1'b1; ustrm_beat_vld = 1'b1; ustrm_beat = a;
    tick();
    m_gen2_mode = 1'b0; ustrm_beat = b;
    tick();
    ustrm_beat = c;
    tick();
    ustrm_beat_vld = 1'b0;
    repeat (2) tick();
    check_eq("mc_wcnt", BW'(word_cnt), BW'(15));

    // ---- reset while HALF ----
    m_gen2_mode = 1'b1;
    a = mk_beat(8'h81);
    ustrm_beat_vld = 1'b1; ustrm_beat = a;
    tick();
    ustrm_beat_vld = 1'b0;
    #1; check_eq("rh_busy_before", BW'(busy), BW'(1));
    rst_wr_n = 1'b0;
    tick();
    check_eq("rh_push", BW'(txfifo_push), BW'(0));
    tick();
    rst_wr_n = 1'b1;
    check_eq("rh_busy",  BW'(busy), BW'(0));
    check_eq("rh_data",  txfifo_upstream_data[BEAT_W-1:0], zero);
    check_eq("rh_wcnt",  BW'(word_cnt), BW'(0));
    check_eq("rh_pcnt",  BW'(pad_cnt), BW'(0));
    repeat (2) tick();

    // ---- word counter wrap ----
    force dut.word_cnt_q = 16'hFFFF;
    release dut.word_cnt_q;
    #1; check_eq("wrap_preload", BW'(word_cnt), BW'(16'hFFFF));
    m_gen2_mode = 1'b0;
    a = mk_beat(8'h91);
    sb.push_back(mk_exp(a, zero, cyc + 1));
    ustrm_beat_vld = 1'b1; ustrm_beat = a;
    tick();
    ustrm_beat_vld = 1'b0;
    repeat (2) tick();
    check_eq("wrap_wcnt", BW'(word_cnt), BW'(0));

    // ---- drain: every expected word must have been pushed ----
    repeat (3) tick();
    check_eq("sb_empty", BW'(sb.size()), BW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lpif_tx_half_pack_ctrl.md
# lpif_tx_half_pack_ctrl

Sequencing controller for the upstream half of the x16 asymmetric LPIF link. It accepts one 537-bit LPIF beat per cycle from the adapter and packs two consecutive beats into one 1074-bit TX FIFO word, lower half first. In gen1 mode it instead issues one beat per word. It owns the FIFO push handshake, flush padding and word/pad counters. It sits between the LPIF upstream adapter and the TX FIFO feeding the AIB logic link.

## Interface
- BEAT_W, 537: one LPIF beat, packed as {valid, crc_valid, crc[15:0], dvalid, data[511:0], protid[1:0], state[3:0]}, state at LSB.
- WORD_W, 2*BEAT_W (1074): TX FIFO word width.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk_wr  input  1  write-domain clock; the only clock.
- rst_wr_n  input  1  reset, synchronous, active-low.
- m_gen2_mode  input  1  1 = pack two beats per word; 0 = one beat per word, upper half zero.
- ustrm_beat  input  BEAT_W  upstream beat.
- ustrm_beat_vld  input  1  beat valid.
- ustrm_beat_rdy  output  1  beat accepted when vld & rdy.
- flush_req  input  1  pulse: close a half-filled word with a zero pad.
- txfifo_upstream_data  output  WORD_W  registered FIFO word.
- txfifo_push  output  1  FIFO write strobe.
- txfifo_full  input  1  FIFO full.
- busy  output  1  state != EMPTY.
- word_cnt  output  CNT_W  words pushed, wrapping.
- pad_cnt  output  CNT_W  pad-closed words, wrapping.

## Operation
- FSM states: EMPTY, HALF (low half loaded), FULL (word complete, awaiting push).
- txfifo_push = (state == FULL) & ~txfifo_full. Combinational from the state register and txfifo_full. Never asserted while rst_wr_n = 0.
- ustrm_beat_rdy: 1 in EMPTY, 1 in HALF, ~txfifo_full in FULL, 0 while rst_wr_n = 0.
- Gen mode is sampled on every accept made from EMPTY, or from FULL while pushing. A change of m_gen2_mode while in HALF has no effect until that word completes.
- EMPTY, accept, gen2 = 1: beat goes to bits [536:0], next state HALF.
- EMPTY, accept, gen2 = 0: beat goes to [536:0], [1073:537] is set to 0, next state FULL.
- HALF, accept: beat goes to [1073:537], next state FULL.
- HALF, flush_req with no accept: [1073:537] is set to 0, pad_cnt increments, next state FULL.
- HALF, flush_req and accept in the same cycle: the beat wins and the flush is dropped.
- FULL, push, no accept: next state EMPTY.
- FULL, push with accept: the new beat is loaded as if from EMPTY (to HALF or FULL). This gives zero-bubble throughput.
- FULL, txfifo_full: hold state and data. ustrm_beat_rdy = 0.
- flush_req in EMPTY or FULL is ignored.
- word_cnt increments on every txfifo_push. Both counters wrap at 2^CNT_W - 1 → 0.
- Data bits are only written on accept or pad, never on push, so the word stays stable while push is pending.

## Timing
- Reset, sampled on clk_wr: state = EMPTY, txfifo_upstream_data = 0, word_cnt = 0, pad_cnt = 0, busy = 0. txfifo_push = 0 and ustrm_beat_rdy = 0 during reset.
- Gen2 latency: beat A accepted at cycle N and beat B at N+1 gives txfifo_push at N+2 with {B, A}, if not full.
- Gen1 latency: beat accepted at N gives push at N+1.
- Sustained throughput with the FIFO never full: gen2 = one word per 2 cycles; gen1 = one word per cycle.
- txfifo_full is sampled in the same cycle as the push decision. Deassertion at cycle M gives push at M.
- Reset in mid-operation discards any held half-word and any pending word, with no push.

## Structure
- lpif_pack_pkg holds:
  - BEAT_W and WORD_W;
  - field offset localparams (STATE_LSB = 0, PROTID_LSB = 4, DATA_LSB = 6, DVALID = 518, CRC_LSB = 519, CRCV = 535, VALID = 536; upper beat adds BEAT_W);
  - the pack_state_e enum {EMPTY, HALF, FULL}.
- Single flat module; no sub-module is warranted. Counters stay inline.

## Test plan
- Gen2 back-to-back: beats 0x…A1 and 0x…B2 on consecutive cycles, txfifo_full = 0 → push at cycle 2 with upper = B2, lower = A1; word_cnt = 1.
- Gen1 streaming: 8 beats, one per cycle → 8 pushes, one per cycle after 1 cycle of latency; upper half always 0; word_cnt = 8.
- Backpressure: gen2 word complete, txfifo_full held high for 5 cycles → txfifo_push = 0, rdy = 0, data stable; push in the cycle full drops; a beat presented in that cycle is accepted into HALF.
- Flush: one beat, then flush_req → push with upper half 0, pad_cnt = 1. Flush and beat in the same cycle → beat packed, pad_cnt unchanged.
- Mode change in HALF: toggle m_gen2_mode to 0 after the first beat → the second beat still goes to the upper half; the next word follows gen1.
- Reset mid-HALF, and counter wrap: the held half is discarded with no push and busy = 0; word_cnt preloaded (by forcing) to 0xFFFF followed by one push → 0x0000.
